// File: rtl/stage_fetch1.sv
// stage_fetch1: holds the icache request from fetch0 and queues returned
// instructions (or faults) in a 2-entry FIFO feeding decode.
module stage_fetch1 #(
   parameter int QDEPTH = 2
) (
   input  logic        clk_core,
   input  logic        reset_n,
   input  logic        fe0_valid,
   input  logic [29:0] fe0_read_addr,
   output logic        fe1_stall,
   input  logic        icache_ready,
   input  logic [31:0] icache_data,
   input  logic        icache_fault,
   output logic        fe1_valid,
   output logic [29:0] fe1_pc,
   output logic [31:0] fe1_insn,
   output logic        fe1_fault,
   input  logic        de_stall,
   input  logic        de_setpc,
   input  logic        csr_setpc,
   input  logic        csr_kill
);
   logic        r_req_valid;
   logic [29:0] r_req_pc;
   logic [29:0] r_pc [2];
   logic [31:0] r_insn [2];
   logic        r_fault [2];
   logic        r_head;
   logic [1:0]  r_count;
   logic w_flush, w_kill, w_load, w_resp, w_pop, w_full, w_push, w_tail;

   assign w_flush   = de_setpc | csr_setpc;
   assign w_kill    = csr_kill & csr_setpc;
   assign w_load    = fe0_valid & ~w_kill;
   assign w_resp    = r_req_valid & icache_ready;
   assign fe1_valid = r_count != 2'd0;
   assign w_pop     = fe1_valid & ~de_stall;
   assign w_full    = r_count == 2'(QDEPTH);
   // a full queue still accepts a push when the head leaves the same cycle
   assign w_push    = w_resp & ~w_flush & (~w_full | w_pop);
   assign w_tail    = r_head ^ r_count[0];
   assign fe1_stall = r_req_valid & (~icache_ready | (w_full & ~w_pop));
   assign fe1_pc    = fe1_valid ? r_pc[r_head] : 30'd0;
   assign fe1_insn  = fe1_valid ? r_insn[r_head] : 32'd0;
   assign fe1_fault = fe1_valid & r_fault[r_head];

   always_ff @(posedge clk_core) begin
      if (!reset_n) begin
         r_req_valid <= 1'b0;
         r_req_pc    <= 30'd0;
         r_head      <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         if (w_load) begin
            r_req_valid <= 1'b1;
            r_req_pc    <= fe0_read_addr;
         end else if (w_flush | w_push) begin
            r_req_valid <= 1'b0;
         end
         if (w_flush) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
         end else begin
            r_head  <= r_head ^ w_pop;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         end
         if (w_push) begin
            r_pc[w_tail]    <= r_req_pc;
            r_insn[w_tail]  <= icache_fault ? 32'd0 : icache_data;
            r_fault[w_tail] <= icache_fault;
         end
      end
   end
endmodule

// File: tb/tb_stage_fetch1.sv
// tb_stage_fetch1: directed checks of request holding, queueing, stall and flush.
module tb_stage_fetch1;
   logic        clk_core = 1'b0;
   logic        reset_n;
   logic        fe0_valid;
   logic [29:0] fe0_read_addr;
   logic        fe1_stall;
   logic        icache_ready;
   logic [31:0] icache_data;
   logic        icache_fault;
   logic        fe1_valid;
   logic [29:0] fe1_pc;
   logic [31:0] fe1_insn;
   logic        fe1_fault;
   logic        de_stall;
   logic        de_setpc;
   logic        csr_setpc;
   logic        csr_kill;
   int checks = 0;
   int errors = 0;

   stage_fetch1 dut (
      .clk_core(clk_core), .reset_n(reset_n), .fe0_valid(fe0_valid),
      .fe0_read_addr(fe0_read_addr), .fe1_stall(fe1_stall),
      .icache_ready(icache_ready), .icache_data(icache_data),
      .icache_fault(icache_fault), .fe1_valid(fe1_valid), .fe1_pc(fe1_pc),
      .fe1_insn(fe1_insn), .fe1_fault(fe1_fault), .de_stall(de_stall),
      .de_setpc(de_setpc), .csr_setpc(csr_setpc), .csr_kill(csr_kill)
   );

   always #5 clk_core = ~clk_core;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drive one cycle's inputs shortly after the edge, then let them settle
   task automatic drv(input logic fv, input logic [29:0] a, input logic rdy,
                      input logic [31:0] d, input logic flt, input logic ds);
      fe0_valid = fv; fe0_read_addr = a; icache_ready = rdy;
      icache_data = d; icache_fault = flt; de_stall = ds;
      #1;
   endtask

   task automatic nx();
      @(posedge clk_core);
      #1;
   endtask

   task automatic head(input string tag, input logic [29:0] pc, input logic [31:0] insn);
      chk({tag, "_valid"}, 32'(fe1_valid), 32'd1);
      chk({tag, "_pc"}, 32'(fe1_pc), 32'(pc));
      chk({tag, "_insn"}, fe1_insn, insn);
   endtask

   initial begin
      int stalls;
      reset_n = 1'b0; de_setpc = 1'b0; csr_setpc = 1'b0; csr_kill = 1'b0;
      drv(0, 0, 0, 0, 0, 0);
      nx(); nx();
      chk("rst_valid", 32'(fe1_valid), 0);
      chk("rst_stall", 32'(fe1_stall), 0);
      chk("rst_pc", 32'(fe1_pc), 0);
      chk("rst_insn", fe1_insn, 0);
      chk("rst_fault", 32'(fe1_fault), 0);
      reset_n = 1'b1;
      // back-to-back hits 0x100..0x103
      for (int i = 0; i < 6; i++) begin
         drv(i < 4, 30'(32'h100 + i), i >= 1 && i <= 4, 32'h1000 + 32'(i) - 1, 0, 0);
         chk("b2b_stall", 32'(fe1_stall), 0);
         if (i >= 2) head("b2b", 30'(32'h100 + i - 2), 32'h1000 + 32'(i) - 2);
         else chk("b2b_early_valid", 32'(fe1_valid), 0);
         nx();
      end
      drv(0, 0, 0, 0, 0, 0);
      chk("b2b_drain", 32'(fe1_valid), 0);
      // miss of 5 cycles at 0x40
      drv(1, 30'h40, 0, 0, 0, 0);
      chk("miss_req_stall", 32'(fe1_stall), 0);
      nx();
      stalls = 0;
      for (int i = 0; i < 5; i++) begin
         drv(0, 0, 0, 0, 0, 0);
         stalls += int'(fe1_stall);
         nx();
      end
      chk("miss_stall_cycles", 32'(stalls), 5);
      drv(0, 0, 1, 32'h0050_0093, 0, 0);
      chk("miss_ready_stall", 32'(fe1_stall), 0);
      chk("miss_not_yet", 32'(fe1_valid), 0);
      nx();
      drv(0, 0, 0, 0, 0, 0);
      head("miss", 30'h40, 32'h0050_0093);
      chk("miss_after_stall", 32'(fe1_stall), 0);
      nx();
      chk("miss_drain", 32'(fe1_valid), 0);
      // backpressure: queue fills, third response stalls
      drv(1, 30'h300, 0, 0, 0, 1);
      nx();
      drv(1, 30'h301, 1, 32'h3000, 0, 1);
      chk("bp_stall1", 32'(fe1_stall), 0);
      nx();
      drv(1, 30'h302, 1, 32'h3001, 0, 1);
      chk("bp_stall2", 32'(fe1_stall), 0);
      head("bp_h1", 30'h300, 32'h3000);
      nx();
      drv(0, 0, 1, 32'h3002, 0, 1);
      chk("bp_stall3", 32'(fe1_stall), 1);
      head("bp_full", 30'h300, 32'h3000);
      nx();
      drv(0, 0, 1, 32'h3002, 0, 1);
      chk("bp_stall_hold", 32'(fe1_stall), 1);
      nx();
      drv(0, 0, 1, 32'h3002, 0, 0);
      chk("bp_release_stall", 32'(fe1_stall), 0);
      head("bp_o0", 30'h300, 32'h3000);
      nx();
      drv(0, 0, 0, 0, 0, 0);
      head("bp_o1", 30'h301, 32'h3001);
      nx();
      drv(0, 0, 0, 0, 0, 0);
      head("bp_o2", 30'h302, 32'h3002);
      nx();
      chk("bp_empty", 32'(fe1_valid), 0);
      // fault
      drv(1, 30'h80, 0, 0, 0, 0);
      nx();
      drv(0, 0, 1, 32'hDEAD_BEEF, 1, 0);
      nx();
      drv(0, 0, 0, 0, 0, 0);
      head("fault", 30'h80, 32'h0);
      chk("fault_flag", 32'(fe1_fault), 1);
      nx();
      chk("fault_drain", 32'(fe1_valid), 0);
      // decode flush with two queued and a miss pending
      drv(1, 30'h500, 0, 0, 0, 1);
      nx();
      drv(1, 30'h501, 1, 32'h5000, 0, 1);
      nx();
      drv(1, 30'h502, 1, 32'h5001, 0, 1);
      nx();
      drv(1, 30'h200, 0, 0, 0, 1);
      de_setpc = 1'b1;
      chk("dflush_pre_stall", 32'(fe1_stall), 1);
      head("dflush_pre", 30'h500, 32'h5000);
      nx();
      de_setpc = 1'b0;
      drv(0, 0, 0, 0, 0, 0);
      chk("dflush_empty", 32'(fe1_valid), 0);
      chk("dflush_miss_stall", 32'(fe1_stall), 1);
      nx();
      drv(0, 0, 1, 32'h2000, 0, 0);
      chk("dflush_ready_stall", 32'(fe1_stall), 0);
      nx();
      drv(0, 0, 0, 0, 0, 0);
      head("dflush_new", 30'h200, 32'h2000);
      nx();
      chk("dflush_only", 32'(fe1_valid), 0);
      // CSR redirect during a miss discards the old response
      drv(1, 30'h700, 0, 0, 0, 0);
      nx();
      drv(1, 30'h710, 1, 32'h7000, 0, 0);
      csr_setpc = 1'b1;
      nx();
      csr_setpc = 1'b0;
      drv(0, 0, 0, 0, 0, 0);
      chk("csr_old_dropped", 32'(fe1_valid), 0);
      chk("csr_new_stall", 32'(fe1_stall), 1);
      nx();
      drv(0, 0, 1, 32'h7100, 0, 0);
      nx();
      drv(0, 0, 0, 0, 0, 0);
      head("csr_new", 30'h710, 32'h7100);
      nx();
      // CSR kill during a miss
      drv(1, 30'h600, 0, 0, 0, 0);
      nx();
      drv(0, 0, 0, 0, 0, 0);
      chk("kill_pre_stall", 32'(fe1_stall), 1);
      csr_setpc = 1'b1; csr_kill = 1'b1;
      nx();
      csr_setpc = 1'b0; csr_kill = 1'b0;
      drv(0, 0, 1, 32'h6000, 0, 0);
      chk("kill_no_req", 32'(fe1_stall), 0);
      chk("kill_empty", 32'(fe1_valid), 0);
      nx();
      drv(0, 0, 0, 0, 0, 0);
      chk("kill_nothing", 32'(fe1_valid), 0);
      // reset with two entries queued
      drv(1, 30'h900, 0, 0, 0, 1);
      nx();
      drv(1, 30'h901, 1, 32'h9000, 0, 1);
      nx();
      drv(0, 0, 1, 32'h9001, 0, 1);
      nx();
      drv(0, 0, 0, 0, 0, 1);
      head("rst2_pre", 30'h900, 32'h9000);
      reset_n = 1'b0;
      nx();
      reset_n = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      chk("rst2_valid", 32'(fe1_valid), 0);
      chk("rst2_stall", 32'(fe1_stall), 0);
      chk("rst2_pc", 32'(fe1_pc), 0);
      chk("rst2_insn", fe1_insn, 0);
      chk("rst2_fault", 32'(fe1_fault), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
